// File: rtl/risc_fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction-memory request/ack port plus the decode hand-off.
// master = fetch controller, slave = memory/decode side.
interface risc_fetch_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic                  imem_ack;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic                  inst_valid;
    logic [DATA_WIDTH-1:0] inst_data;
    logic [DATA_WIDTH-1:0] inst_pc;
    logic                  inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
        input  imem_ack, imem_rdata, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
        output imem_ack, imem_rdata, inst_ready
    );
endinterface

// File: rtl/risc_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the req/ack memory port and
// holds one fetched instruction for decode; branch redirects squash wrong-path fetches.
module risc_fetch_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  halt,
    risc_fetch_ctrl_if.master     bus,
    input  logic                  br_valid,
    input  logic [DATA_WIDTH-1:0] br_pc,
    input  logic [DATA_WIDTH-1:0] br_offset,
    output logic [DATA_WIDTH-1:0] fetch_pc
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } state_e;

    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(3'd4);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic                  req_q, req_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] ipc_q, ipc_d;
    logic [DATA_WIDTH-1:0] target_s;
    logic [DATA_WIDTH-1:0] pc_adv_s;
    logic                  capture_s;
    logic                  fetch_start_s;

    assign target_s = br_pc + {br_offset[DATA_WIDTH-2:0], 1'b0};

    // State and datapath registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_ADDR;
            addr_q  <= RESET_ADDR;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ipc_q   <= ipc_d;
        end
    end

    // Next state and PC; a redirect always overrides the sequential PC
    always_comb begin
        state_d  = state_q;
        pc_adv_s = pc_q;
        case (state_q)
            ST_IDLE: begin
                if (!halt) state_d = ST_REQ;
                else       state_d = ST_IDLE;
            end
            ST_REQ: begin
                if (bus.imem_ack) begin
                    if (br_valid) begin
                        state_d = halt ? ST_IDLE : ST_REQ;
                    end else begin
                        state_d  = ST_HOLD;
                        pc_adv_s = addr_q + PC_STEP;
                    end
                end else if (br_valid) begin
                    state_d = ST_DROP;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (br_valid || bus.inst_ready) state_d = halt ? ST_IDLE : ST_REQ;
                else                            state_d = ST_HOLD;
            end
            ST_DROP: begin
                if (bus.imem_ack) state_d = halt ? ST_IDLE : ST_REQ;
                else              state_d = ST_DROP;
            end
            default: state_d = ST_IDLE;
        endcase
        if (br_valid) pc_d = target_s;
        else          pc_d = pc_adv_s;
    end

    // Output register next values; a new request always carries the post-edge PC
    always_comb begin
        fetch_start_s = (state_d == ST_REQ) && ((state_q != ST_REQ) || bus.imem_ack);
        capture_s     = (state_q == ST_REQ) && bus.imem_ack && !br_valid;
        req_d         = (state_d == ST_REQ) || (state_d == ST_DROP);
        valid_d       = (state_d == ST_HOLD);
        if (fetch_start_s) addr_d = pc_d;
        else               addr_d = addr_q;
        if (capture_s) begin
            data_d = bus.imem_rdata;
            ipc_d  = addr_q;
        end else begin
            data_d = data_q;
            ipc_d  = ipc_q;
        end
    end

    assign bus.imem_req   = req_q;
    assign bus.imem_addr  = addr_q;
    assign bus.inst_valid = valid_q;
    assign bus.inst_data  = data_q;
    assign bus.inst_pc    = ipc_q;
    assign fetch_pc       = pc_q;
endmodule

// File: tb/tb_risc_fetch_ctrl.sv
// Self-checking bench for risc_fetch_ctrl: directed scenarios then random traffic,
// compared every cycle against a transaction-level model of the fetch unit.
module tb_risc_fetch_ctrl;
    logic        clk = 1'b0;
    logic        nrst;
    logic        halt;
    logic        br_valid;
    logic [31:0] br_pc;
    logic [31:0] br_offset;
    logic [31:0] fetch_pc;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Model: an outstanding fetch (possibly squashed) and an optional held instruction.
    logic        m_busy, m_squash, m_have;
    logic [31:0] m_pc, m_addr, m_data, m_ipc;

    risc_fetch_ctrl_if #(.DATA_WIDTH(32)) bus ();

    risc_fetch_ctrl #(.DATA_WIDTH(32), .RESET_ADDR(32'h0)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .halt      (halt),
        .bus       (bus),
        .br_valid  (br_valid),
        .br_pc     (br_pc),
        .br_offset (br_offset),
        .fetch_pc  (fetch_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_squash = 1'b0; m_have = 1'b0;
        m_pc = 32'h0; m_addr = 32'h0; m_data = 32'h0; m_ipc = 32'h0;
    endtask

    task automatic model_edge();
        logic [31:0] tgt;
        logic        start;
        tgt   = br_pc + (br_offset << 1);
        start = 1'b0;
        if (m_busy) begin
            if (bus.imem_ack) begin
                m_busy = 1'b0;
                if (br_valid) begin
                    m_pc  = tgt;
                    start = !halt;
                end else if (m_squash) begin
                    start = !halt;
                end else begin
                    m_have = 1'b1;
                    m_data = bus.imem_rdata;
                    m_ipc  = m_addr;
                    m_pc   = m_addr + 32'd4;
                end
            end else if (br_valid) begin
                m_pc     = tgt;
                m_squash = 1'b1;
            end
        end else if (m_have) begin
            if (br_valid) begin
                m_have = 1'b0;
                m_pc   = tgt;
                start  = !halt;
            end else if (bus.inst_ready) begin
                m_have = 1'b0;
                start  = !halt;
            end
        end else begin
            if (br_valid) m_pc = tgt;
            start = !halt;
        end
        if (start) begin
            m_busy   = 1'b1;
            m_squash = 1'b0;
            m_addr   = m_pc;
        end
    endtask

    task automatic check_all();
        chk("imem_req",   {31'b0, bus.imem_req},   {31'b0, m_busy});
        chk("imem_addr",  bus.imem_addr,           m_addr);
        chk("inst_valid", {31'b0, bus.inst_valid}, {31'b0, m_have});
        chk("inst_data",  bus.inst_data,           m_data);
        chk("inst_pc",    bus.inst_pc,             m_ipc);
        chk("fetch_pc",   fetch_pc,                m_pc);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        bus.imem_rdata = $urandom;
    endtask

    initial begin
        nrst = 1'b0; halt = 1'b0; br_valid = 1'b0; br_pc = 32'h0; br_offset = 32'h0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'h1234_5678; bus.inst_ready = 1'b1;
        model_reset();
        #12;
        check_all();
        chk("reset_req", {31'b0, bus.imem_req}, 32'h0);
        nrst = 1'b1;

        tick();
        chk("first_req", {31'b0, bus.imem_req}, 32'h1);
        chk("first_addr", bus.imem_addr, 32'h0);

        // Sequential fetch, one instruction per two cycles
        for (int i = 0; i < 3; i++) begin
            bus.imem_ack = 1'b1; tick();
            bus.imem_ack = 1'b0; tick();
        end
        chk("seq_addr", bus.imem_addr, 32'hC);

        // Decode stall in HOLD
        bus.imem_ack = 1'b1; tick();
        bus.imem_ack = 1'b0; bus.inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("stall_valid", {31'b0, bus.inst_valid}, 32'h1);
        chk("stall_ipc", bus.inst_pc, 32'hC);
        bus.inst_ready = 1'b1; tick();
        chk("stall_next_addr", bus.imem_addr, 32'h10);

        // Redirect from HOLD, positive and negative offsets
        bus.imem_ack = 1'b1; tick();
        bus.imem_ack = 1'b0; bus.inst_ready = 1'b0;
        br_valid = 1'b1; br_pc = 32'h10; br_offset = 32'h8; tick();
        chk("hold_br_valid", {31'b0, bus.inst_valid}, 32'h0);
        chk("hold_br_addr", bus.imem_addr, 32'h20);
        br_valid = 1'b0; bus.imem_ack = 1'b1; tick();
        bus.imem_ack = 1'b0;
        br_valid = 1'b1; br_pc = 32'h10; br_offset = 32'hFFFF_FFFC; tick();
        chk("hold_br_neg_addr", bus.imem_addr, 32'h8);
        br_valid = 1'b0; bus.inst_ready = 1'b1;

        // Redirect in REQ with delayed ack, second redirect in DROP wins
        br_valid = 1'b1; br_pc = 32'h10; br_offset = 32'h8; tick();
        chk("drop_addr_held", bus.imem_addr, 32'h8);
        br_valid = 1'b0; tick();
        br_valid = 1'b1; br_pc = 32'h40; br_offset = 32'h10; tick();
        br_valid = 1'b0; bus.imem_ack = 1'b1; tick();
        chk("drop_valid", {31'b0, bus.inst_valid}, 32'h0);
        chk("drop_new_addr", bus.imem_addr, 32'h60);

        // Halt raised during REQ: fetch completes, then idles after accept
        halt = 1'b1; tick();
        bus.imem_ack = 1'b0; tick();
        chk("halt_idle_req", {31'b0, bus.imem_req}, 32'h0);
        tick(); tick();
        halt = 1'b0; tick();
        chk("halt_resume_addr", bus.imem_addr, 32'h64);

        // Asynchronous reset while in DROP
        br_valid = 1'b1; br_pc = 32'h10; br_offset = 32'h8; tick();
        br_valid = 1'b0;
        #3 nrst = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_rst_req", {31'b0, bus.imem_req}, 32'h0);
        #1 nrst = 1'b1;
        tick();
        chk("refetch_addr", bus.imem_addr, 32'h0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            halt           = ($urandom_range(0, 7) == 0);
            bus.imem_ack   = $urandom_range(0, 1) == 1;
            bus.inst_ready = $urandom_range(0, 3) != 0;
            br_valid       = ($urandom_range(0, 9) == 0);
            br_pc          = $urandom;
            br_offset      = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 64)) - 32'd32;
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
